// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: two requester ports plus the data memory port.
// Valid/ready semantics: a requester holds reqN/weN/addrN/wdataN stable while
// reqN=1; the access happens in the cycle readyN=1 (combinational grant), and
// a load returns rdataN with rvalidN=1 exactly one cycle later. reqN may drop
// before readyN, in which case the access is simply not performed.
interface dmem_arbiter_if;
  logic        req0;
  logic        we0;
  logic [31:0] addr0;
  logic [31:0] wdata0;
  logic        ready0;
  logic [31:0] rdata0;
  logic        rvalid0;

  logic        req1;
  logic        we1;
  logic [31:0] addr1;
  logic [31:0] wdata1;
  logic        ready1;
  logic [31:0] rdata1;
  logic        rvalid1;

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  // Arbiter side
  modport slave (
    input  req0, we0, addr0, wdata0,
    output ready0, rdata0, rvalid0,
    input  req1, we1, addr1, wdata1,
    output ready1, rdata1, rvalid1,
    output mem_we, mem_addr, mem_write_data,
    input  mem_read_data
  );

  // Requester / memory side
  modport master (
    output req0, we0, addr0, wdata0,
    input  ready0, rdata0, rvalid0,
    output req1, we1, addr1, wdata1,
    input  ready1, rdata1, rvalid1,
    input  mem_we, mem_addr, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data memory arbiter. Port 0 (CPU) has fixed priority; a starvation
// counter forces a grant to port 1 (debug loader) after STARVE_LIMIT denials.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  dmem_arbiter_if.slave    bus,
  output logic             o_dbg_state,
  output logic [CNT_W-1:0] o_dbg_starve_cnt
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]      conflict_cnt,
  output logic [31:0]      force_cnt
`endif
);

  typedef enum logic {PRI0 = 1'b0, FORCE1 = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_deny1;
  logic [31:0]      r_rdata0;
  logic [31:0]      r_rdata1;
  logic             r_rvalid0;
  logic             r_rvalid1;

  // Port 1 wants the memory but priority mode handed the cycle to port 0
  assign w_deny1 = (r_state == PRI0) && bus.req1 && !w_gnt1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= PRI0;
    else     r_state <= w_state_nxt;
  end

  // Next-state: escalate to FORCE1 on the last tolerated denial, drop back after one cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PRI0:    if (w_deny1 && (r_starve_cnt == LIMIT_M1)) w_state_nxt = FORCE1;
      FORCE1:  if (w_gnt0 || w_gnt1 || (!bus.req0 && !bus.req1)) w_state_nxt = PRI0;
      default: w_state_nxt = PRI0;
    endcase
  end

  // Grant outputs: priority order depends on the state; nothing granted in reset
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst) begin
      case (r_state)
        PRI0: begin
          w_gnt0 = bus.req0;
          w_gnt1 = !bus.req0 && bus.req1;
        end
        FORCE1: begin
          w_gnt1 = bus.req1;
          w_gnt0 = !bus.req1 && bus.req0;
        end
        default: begin
          w_gnt0 = 1'b0;
          w_gnt1 = 1'b0;
        end
      endcase
    end
  end

  // Memory port follows the granted requester; addr0 parks the bus when idle
  assign bus.mem_we         = (w_gnt0 && bus.we0) || (w_gnt1 && bus.we1);
  assign bus.mem_addr       = w_gnt1 ? bus.addr1  : bus.addr0;
  assign bus.mem_write_data = w_gnt1 ? bus.wdata1 : bus.wdata0;
  assign bus.ready0         = w_gnt0;
  assign bus.ready1         = w_gnt1;

  // Starvation counter: counts consecutive priority-mode denials of port 1
  always_ff @(posedge clk) begin
    if (rst)                          r_starve_cnt <= '0;
    else if (w_deny1) begin
      if (r_starve_cnt != LIMIT)      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
    else                              r_starve_cnt <= '0;
  end

  // Read return: capture the asynchronous memory read at the end of the grant cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt0 && !bus.we0;
      r_rvalid1 <= w_gnt1 && !bus.we1;
      if (w_gnt0 && !bus.we0) r_rdata0 <= bus.mem_read_data;
      if (w_gnt1 && !bus.we1) r_rdata1 <= bus.mem_read_data;
    end
  end

  assign bus.rdata0       = r_rdata0;
  assign bus.rdata1       = r_rdata1;
  assign bus.rvalid0      = r_rvalid0;
  assign bus.rvalid1      = r_rvalid1;
  assign o_dbg_state      = r_state;
  assign o_dbg_starve_cnt = r_starve_cnt;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] r_conflict_cnt;
  logic [31:0] r_force_cnt;

  // Statistics: cycles with both ports requesting, and forced grants to port 1
  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict_cnt <= '0;
      r_force_cnt    <= '0;
    end else begin
      if (bus.req0 && bus.req1)             r_conflict_cnt <= r_conflict_cnt + 32'd1;
      if ((r_state == FORCE1) && w_gnt1)    r_force_cnt    <= r_force_cnt + 32'd1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
  assign force_cnt    = r_force_cnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter. Builds with or without DMEM_ARB_STATS_EN.
module tb_dmem_arbiter;
  logic       clk;
  logic       rst;
  logic       dbg_state;
  logic [3:0] dbg_starve_cnt;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] conflict_cnt;
  logic [31:0] force_cnt;
`endif

  dmem_arbiter_if bus ();

  dmem_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .o_dbg_state      (dbg_state),
    .o_dbg_starve_cnt (dbg_starve_cnt)
`ifdef DMEM_ARB_STATS_EN
    ,
    .conflict_cnt     (conflict_cnt),
    .force_cnt        (force_cnt)
`endif
  );

  // ---------------- clock / memory model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem     [0:16383];
  logic [31:0] ref_mem [0:16383];

  assign bus.mem_read_data = mem[bus.mem_addr[15:2]];

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[15:2]] <= bus.mem_write_data;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] last0, last1;
  logic        pend0, pend1;
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive both requesters, check grant and memory port
  // mid-cycle, then check the registered read return after the edge.
  task automatic cycle(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic e0, input logic e1);
    logic [31:0] v;
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    @(negedge clk);
    chk("ready0", bus.ready0, e0);
    chk("ready1", bus.ready1, e1);
    chk("mem_we", bus.mem_we, (e0 && w0) || (e1 && w1));
    if (e1) chk("mem_addr_p1", bus.mem_addr, a1);
    else    chk("mem_addr_p0", bus.mem_addr, a0);
    if (e0 && w0) chk("mem_wdata_p0", bus.mem_write_data, d0);
    if (e1 && w1) chk("mem_wdata_p1", bus.mem_write_data, d1);
    pend0 = e0 && !w0;
    pend1 = e1 && !w1;
    if (pend0) exp_q0.push_back(ref_mem[a0[15:2]]);
    if (pend1) exp_q1.push_back(ref_mem[a1[15:2]]);
    if (e0 && w0) ref_mem[a0[15:2]] = d0;
    if (e1 && w1) ref_mem[a1[15:2]] = d1;
    @(posedge clk);
    #1;
    chk("rvalid0", bus.rvalid0, pend0);
    chk("rvalid1", bus.rvalid1, pend1);
    if (pend0) begin
      v = exp_q0.pop_front();
      chk("rdata0", bus.rdata0, v);
      last0 = v;
    end else begin
      chk("rdata0_hold", bus.rdata0, last0);
    end
    if (pend1) begin
      v = exp_q1.pop_front();
      chk("rdata1", bus.rdata1, v);
      last1 = v;
    end else begin
      chk("rdata1_hold", bus.rdata1, last1);
    end
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 32'h0000_0200, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    last0 = '0;
    last1 = '0;
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("rst_state", dbg_state, 1'b0);
    chk("rst_starve", dbg_starve_cnt, 4'd0);
    rst = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic p1_pat [0:7];
    for (int i = 0; i < 16384; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    rst = 1'b1;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;

    do_reset();

    // Port 0 alone: store then load 0x10
    cycle(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 32'h10, 32'h0,         1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle();
    idle();

    // Port 1 store to 0x40, port 0 reads it back next cycle
    cycle(1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b1, 32'h40, 32'h1234_5678, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0);
    idle();

    // Preload 0x0/0x4/0x8 from port 0, then port 1 back-to-back loads
    cycle(1'b1, 1'b1, 32'h0, 32'hA0A0_0001, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 32'h4, 32'hB0B0_0002, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 32'h8, 32'hC0C0_0003, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b1);
    idle();

    // Starvation: both ports loading for 10 cycles, port 1 forced in on 4 and 9
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0,
            (i != 4) && (i != 9), (i == 4) || (i == 9));
      if (i == 3) chk("state_force1", dbg_state, 1'b1);
      if (i == 4) chk("state_back_pri0", dbg_state, 1'b0);
    end
    idle();
`ifdef DMEM_ARB_STATS_EN
    chk("conflict_cnt", conflict_cnt, 32'd10);
    chk("force_cnt", force_cnt, 32'd2);
`endif

    // Dropping req1 clears the starvation count, so the forced grant comes later
    p1_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 32'h10, 32'h0, p1_pat[i], 1'b0, 32'h40, 32'h0, i != 7, i == 7);
    end
    idle();

    // Reset asserted during a port 0 store: the store must not land
    cycle(1'b1, 1'b1, 32'h80, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    rst = 1'b1;
    last0 = '0;
    last1 = '0;
    cycle(1'b1, 1'b1, 32'h80, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("rst_mid_state", dbg_state, 1'b0);
    cycle(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter sharing the single data memory between requester 0 (CPU MEM stage) and requester 1 (debug/trace loader).
- The data memory has asynchronous read and synchronous write, on a 32-bit word address `addr[15:2]`.
- The arbiter selects one requester per cycle, drives the memory port, and returns registered read data with a valid strobe.
- Port 0 has fixed priority; a starvation counter guarantees port 1 service.

Parameters:
- STARVE_LIMIT, 4: max consecutive cycles port 1 may be denied before a forced grant (1..15).
- CNT_W, 4: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  port 0 access request.
- we0  input  1  port 0 write enable (1 = store, 0 = load).
- addr0  input  32  port 0 byte address; bits [1:0] ignored.
- wdata0  input  32  port 0 write data.
- ready0  output  1  port 0 request accepted this cycle.
- rdata0  output  32  port 0 read data, registered.
- rvalid0  output  1  rdata0 valid (one cycle after an accepted load).
- req1, we1, addr1, wdata1, ready1, rdata1, rvalid1: same as the port 0 signals, for port 1.
- mem_we  output  1  to data memory write enable.
- mem_addr  output  32  to data memory address; memory uses [15:2].
- mem_write_data  output  32  to data memory write data.
- mem_read_data  input  32  from data memory, combinational read.

Behaviour:
- Reset: ready0/1=0, rvalid0/1=0, rdata0/1=0, starve_cnt=0, state=PRI0. mem_we is forced 0 while rst=1.
- Requester rule: hold req/we/addr/wdata stable until the readyN cycle. Dropping req before ready is legal; the request is simply not serviced.
- Grant is combinational in the request cycle: readyN=1 in the same cycle the memory access happens. At most one of ready0/ready1 is high in any cycle.
- FSM state PRI0:
  - grant port 0 if req0.
  - else grant port 1 if req1.
- FSM state FORCE1:
  - grant port 1 if req1.
  - else grant port 0 if req0.
- Memory port:
  - mem_addr/mem_write_data carry the granted port's values.
  - mem_we = granted we.
  - With no grant: mem_we=0 and mem_addr = addr0 (don't-care, but stable).
- Write: committed at the clock edge of the ready cycle. rvalid stays 0 for writes.
- Read: mem_read_data is captured into rdataN at the edge of the ready cycle; rvalidN=1 for exactly the next cycle. rdataN holds its last value afterwards.
- Starvation counter:
  - In PRI0, if req1=1 and port 1 is not granted: starve_cnt += 1 (saturating at STARVE_LIMIT).
  - When port 1 is granted, or req1=0: starve_cnt clears to 0.
- Transitions:
  - PRI0 -> FORCE1 when starve_cnt == STARVE_LIMIT-1 and port 1 is denied again this cycle. Port 1 is therefore granted on the next cycle if still requesting.
  - FORCE1 -> PRI0 after any single grant, or if neither port requests.
- Same-address read after write, different ports: the read sees the new data if the write was granted in an earlier cycle. No same-cycle forwarding is needed, since only one access occurs per cycle.
- Reset mid-operation: a pending rvalid is cleared and an in-flight write is not committed if rst=1 at that edge. The FSM returns to PRI0.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Adds output conflict_cnt [31:0], incremented every cycle both req0 and req1 are high. Wraps at 2^32.
  - Adds output force_cnt [31:0], incremented on each FORCE1 grant to port 1.
  - Both counters are cleared by rst.
- Undefined: neither port nor any counter logic exists; all other behaviour is identical.

Test Plan:
- Port 0 alone: we0=1, addr0=0x10, wdata0=0xDEADBEEF, then a load from 0x10 -> ready0=1 in each request cycle; rvalid0=1 with rdata0=0xDEADBEEF one cycle after the load's ready.
- Simultaneous req0/req1 loads, STARVE_LIMIT=4, req0 held high continuously -> port 0 granted cycles 0-3; ready1=1 on cycle 4; port 0 resumes on cycle 5.
- Port 1 writes 0x12345678 to 0x40, then port 0 loads 0x40 in the following cycle -> rdata0=0x12345678; ready0 and ready1 never high together.
- Port 1 alone, back-to-back loads 0x0, 0x4, 0x8 -> ready1 every cycle, rvalid1 for 3 consecutive cycles with the matching data.
- rst asserted in the cycle a port 0 store is granted -> memory content at that address unchanged; all outputs 0 next cycle; FSM in PRI0.
- With DMEM_ARB_STATS_EN, 10 cycles of both ports requesting -> conflict_cnt=10, force_cnt=2.
